// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
// The one-hot helper is sized for the widest supported select; callers cast to their width.
package decoder_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam int DWELL_MIN = 1;
  localparam int SEL_W_MAX = 10;
  localparam int OUT_W_MAX = 2 ** SEL_W_MAX;

  function automatic logic [OUT_W_MAX-1:0] onehot(input logic [SEL_W_MAX-1:0] sel);
    onehot = '0;
    onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with output enable.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int SEL_W = 5
) (
  input  logic [SEL_W-1:0]      i_sel,
  input  logic                  i_en,
  output logic [2**SEL_W-1:0]   o_dout
);

  localparam int OUT_W = 2 ** SEL_W;

  assign o_dout = i_en ? OUT_W'(onehot(SEL_W_MAX'(i_sel))) : '0;

endmodule

// File: rtl/decoder_scan_seq.sv
// Registered one-hot decoder: direct decode of a host select, or a timed scan
// across all outputs with pause, abort, single-pass and continuous modes.
module decoder_scan_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 5,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [2**SEL_W-1:0]  dout,
  output logic [SEL_W-1:0]     cur_sel,
  output logic                 busy,
  output logic                 wrap,
  output logic                 done
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam logic [SEL_W-1:0]   LAST_SEL   = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0]   SEL_ONE    = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0]   SLOT0      = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(DWELL_MIN);

  scan_state_t        r_state;
  logic [OUT_W-1:0]   r_dout;
  logic [SEL_W-1:0]   r_cur_sel;
  logic               r_busy;
  logic               r_wrap;
  logic               r_done;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwell_l;
  logic               r_loop_l;
  logic [OUT_W-1:0]   w_dec;
  logic               w_abort;

  decoder_core #(.SEL_W(SEL_W)) u_core (
    .i_sel  (sel),
    .i_en   (en),
    .o_dout (w_dec)
  );

  // Leaving scan mode counts as an abort, same as an explicit stop.
  assign w_abort = stop | ~mode;

  // Scan sequencer and registered decoder outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_dout    <= '0;
      r_cur_sel <= '0;
      r_busy    <= 1'b0;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_dwell_l <= '0;
      r_loop_l  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!mode) begin
            r_dout <= w_dec;
            if (en) begin
              r_cur_sel <= sel;
            end
          end else if (start && !stop) begin
            r_dwell_l <= (dwell == '0) ? DWELL_ONE : dwell;
            r_loop_l  <= loop;
            r_cnt     <= DWELL_ONE;
            r_cur_sel <= '0;
            r_dout    <= SLOT0;
            r_busy    <= 1'b1;
            r_state   <= SCAN;
          end else begin
            r_dout <= '0;
          end
        end
        SCAN: begin
          if (w_abort) begin
            r_dout  <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (en) begin
            if (r_cnt != r_dwell_l) begin
              r_cnt <= r_cnt + DWELL_ONE;
            end else if (r_cur_sel != LAST_SEL) begin
              r_cnt     <= DWELL_ONE;
              r_cur_sel <= r_cur_sel + SEL_ONE;
              r_dout    <= {r_dout[OUT_W-2:0], 1'b0};
            end else if (r_loop_l) begin
              r_cnt     <= DWELL_ONE;
              r_cur_sel <= '0;
              r_dout    <= SLOT0;
              r_wrap    <= 1'b1;
            end else begin
              r_dout  <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_state <= IDLE;
          r_dout  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout    = r_dout;
  assign cur_sel = r_cur_sel;
  assign busy    = r_busy;
  assign wrap    = r_wrap;
  assign done    = r_done;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_decoder_scan_seq;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [4:0]  sel;
  logic        start;
  logic        stop;
  logic        loop;
  logic [7:0]  dwell;
  logic [31:0] dout;
  logic [4:0]  cur_sel;
  logic        busy;
  logic        wrap;
  logic        done;

  decoder_scan_seq #(.SEL_W(5), .DWELL_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .sel     (sel),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .dwell   (dwell),
    .dout    (dout),
    .cur_sel (cur_sel),
    .busy    (busy),
    .wrap    (wrap),
    .done    (done)
  );

  typedef struct {
    int          cyc;
    logic [31:0] dout;
    logic [4:0]  sel;
    bit          sel_chk;
    logic        busy;
    logic        wrap;
    logic        done;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_x;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // scan model state
  int m_e;
  int m_dw;
  bit m_loop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input exp_t x);
    total++;
    if (dout !== x.dout || busy !== x.busy || wrap !== x.wrap || done !== x.done ||
        (x.sel_chk && cur_sel !== x.sel)) begin
      bad++;
      $display("FAIL %s cyc=%0d: got dout=%h sel=%0d busy=%b wrap=%b done=%b, want dout=%h sel=%0d(chk=%0d) busy=%b wrap=%b done=%b",
               x.name, cyc, dout, cur_sel, busy, wrap, done,
               x.dout, x.sel, x.sel_chk, x.busy, x.wrap, x.done);
    end
  endtask

  // Monitor: compares every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_x = q.pop_front();
      if (mon_x.cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s stale: scheduled cyc=%0d seen at cyc=%0d", mon_x.name, mon_x.cyc, cyc);
      end else begin
        check(mon_x);
      end
    end
  end

  function automatic exp_t mk(input string nm, input logic [31:0] d, input logic [4:0] s,
                              input bit sc, input logic b, input logic w, input logic dn);
    exp_t x;
    x.cyc = cyc + 1; x.dout = d; x.sel = s; x.sel_chk = sc;
    x.busy = b; x.wrap = w; x.done = dn; x.name = nm;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_idle(input string nm);
    q.push_back(mk(nm, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
  endtask

  task automatic start_scan(input logic [7:0] dw, input bit lp);
    mode = 1'b1; dwell = dw; loop = lp; start = 1'b1; stop = 1'b0;
    m_dw = (dw == 8'd0) ? 1 : int'(dw);
    m_loop = lp;
    m_e = 0;
    q.push_back(mk("scan_start", 32'h1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    step();
    start = 1'b0;
  endtask

  task automatic scan_step(input string nm);
    int slot;
    if (en) m_e++;
    if (!m_loop && m_e == 32 * m_dw) begin
      q.push_back(mk({nm, "_done"}, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    end else begin
      slot = (m_e / m_dw) % 32;
      q.push_back(mk(nm, 32'h1 << slot, 5'(slot), 1'b1, 1'b1,
                     (en && m_loop && m_e > 0 && (m_e % (32 * m_dw)) == 0), 1'b0));
    end
    step();
  endtask

  initial begin
    exp_t x;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 5'd0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; dwell = 8'd0;
    #3;
    x = mk("reset", 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check(x);
    step();
    rst_n = 1'b1;

    // 1. direct decode sweep
    en = 1'b1;
    for (int s = 0; s < 32; s++) begin
      sel = 5'(s);
      q.push_back(mk("direct", 32'h1 << s, 5'(s), 1'b1, 1'b0, 1'b0, 1'b0));
      step();
    end
    en = 1'b0; sel = 5'd9;
    q.push_back(mk("direct_en0", 32'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0));
    step();

    // 2. single pass, dwell 3
    en = 1'b1;
    start_scan(8'd3, 1'b0);
    repeat (96) scan_step("single");
    push_idle("single_after");

    // 3. continuous, dwell 0 -> 1, mid-scan dwell/loop changes ignored, then stop
    start_scan(8'd0, 1'b1);
    dwell = 8'd9; loop = 1'b0;
    repeat (70) scan_step("loop");
    stop = 1'b1;
    push_idle("loop_stop");
    stop = 1'b0;
    push_idle("loop_stopped");

    // 4. pause mid-dwell at slot 7
    start_scan(8'd4, 1'b0);
    repeat (29) scan_step("pre_pause");
    en = 1'b0;
    repeat (5) scan_step("pause");
    en = 1'b1;
    repeat (10) scan_step("resume");
    stop = 1'b1;
    push_idle("pause_stop");
    stop = 1'b0;

    // 5. collisions
    start = 1'b1; stop = 1'b1; mode = 1'b1;
    push_idle("start_stop");
    start = 1'b0; stop = 1'b0;
    push_idle("start_stop_after");
    start_scan(8'd2, 1'b1);
    repeat (5) scan_step("busy_scan");
    start = 1'b1; dwell = 8'd1;
    scan_step("start_busy");
    start = 1'b0;
    repeat (3) scan_step("busy_scan2");
    mode = 1'b0;
    push_idle("mode_abort");
    sel = 5'd12;
    q.push_back(mk("direct_after_abort", 32'h1000, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0));
    step();

    // 6. async reset mid-scan at slot 20
    start_scan(8'd1, 1'b1);
    repeat (20) scan_step("pre_reset");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    x = mk("async_reset", 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check(x);
    step();
    rst_n = 1'b1;
    push_idle("reset_idle");

    repeat (2) step();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations never checked", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
